// File: rtl/calc_key_arbiter.sv
// Arbitrates keypad source A and host source B onto one calculator key port; a session is locked until '=' or CA, or until timeout.
// An accepted key appears on keycode/newkey one cycle later. Both readies stay low during the inter-key gap, and the non-owner's ready stays low for the whole session.
module calc_key_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [4:0] a_key,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [4:0] b_key,
  output logic       b_ready,
  output logic [4:0] keycode,
  output logic       newkey,
  output logic [1:0] owner,
  output logic       timeout_flag
);

  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [4:0]    KEY_CA   = 5'b00100;
  localparam logic [4:0]    KEY_EQ   = 5'b00011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t        state;
  logic          last_b;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] idle_cnt;

  logic       gap_open;
  logic       grant_a;
  logic       grant_b;
  logic       acc_a;
  logic       acc_b;
  logic       accept;
  logic       close_key;
  logic       fire;
  logic [4:0] acc_key;

  always_comb begin
    gap_open = (gap_cnt == '0) && !rst;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    case (state)
      // Round robin: A wins a tie only if B was granted last.
      IDLE: begin
        grant_a = a_valid && (!b_valid || last_b);
        grant_b = b_valid && !grant_a;
      end
      OWN_A:   grant_a = a_valid;
      OWN_B:   grant_b = b_valid;
      default: ;
    endcase
    acc_a     = gap_open && grant_a;
    acc_b     = gap_open && grant_b;
    accept    = acc_a || acc_b;
    acc_key   = acc_a ? a_key : b_key;
    close_key = (acc_key == KEY_EQ) || (acc_key == KEY_CA);
    // An accept on the final count wins over the timeout.
    fire      = (state != IDLE) && !accept && (idle_cnt == CNT_FIRE);
  end

  assign a_ready = acc_a;
  assign b_ready = acc_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_b       <= 1'b1;
      gap_cnt      <= '0;
      idle_cnt     <= '0;
      keycode      <= 5'b00000;
      newkey       <= 1'b0;
      owner        <= 2'b00;
      timeout_flag <= 1'b0;
    end else begin
      newkey       <= accept || fire;
      timeout_flag <= fire;

      if (accept || fire)
        gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_ONE;

      if (accept) begin
        keycode  <= acc_key;
        last_b   <= acc_b;
        idle_cnt <= '0;
        if (close_key) begin
          state <= IDLE;
          owner <= 2'b00;
        end else if (acc_a) begin
          state <= OWN_A;
          owner <= 2'b01;
        end else begin
          state <= OWN_B;
          owner <= 2'b10;
        end
      end else if (fire) begin
        keycode  <= KEY_CA;
        last_b   <= (state == OWN_B);
        idle_cnt <= '0;
        state    <= IDLE;
        owner    <= 2'b00;
      end else if (state != IDLE) begin
        if (idle_cnt != CNT_MAX)
          idle_cnt <= idle_cnt + CNT_ONE;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/calc_key_arbiter.md
# calc_key_arbiter

Shares the single keypad-style input of the calculator datapath (`keycode`/`newkey`) between two independent key sources: A (front-panel keypad) and B (host/script port). Each complete calculation belongs to one source from its first key until `=` or `CA`, so keystrokes from the two sources never interleave. Sessions abandoned by their owner are closed by a timeout that injects `CA`. The block sits directly in front of the calculator and drives its `keycode` and `newkey` inputs.

## Interface
Parameters:
- GAP_CYCLES, 2: minimum number of idle cycles between successive `newkey` pulses (≥1).
- TIMEOUT, 1000000: owner inactivity limit in cycles. Must satisfy TIMEOUT > GAP_CYCLES+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_valid  in  1  source A has a key
- a_key  in  5  source A keycode
- a_ready  out  1  A key accepted this cycle when a_valid&&a_ready
- b_valid  in  1  source B has a key
- b_key  in  5  source B keycode
- b_ready  out  1  B key accepted this cycle when b_valid&&b_ready
- keycode  out  5  key to calculator, registered, holds last value
- newkey  out  1  one-cycle strobe qualifying keycode
- owner  out  2  00 none, 01 A, 10 B
- timeout_flag  out  1  one-cycle pulse when a session is force-closed

## Operation
- Key codes: digit = key[4]==1; operator = 010xx; CE 01100; CA 00100; `=` 00011; square 00001; sign 00010.
- Handshake: a source holds valid and key stable until accepted. Valid must not depend on ready. Ready may depend on valid (combinational).
- gap_cnt is loaded with GAP_CYCLES on every cycle `newkey`=1 and decrements to 0. Both ready signals are low while gap_cnt≠0.
- FSM states: IDLE, OWN_A, OWN_B. `last` holds the last granted source; reset value B.
- IDLE, gap_cnt==0:
  - grant A if a_valid && (!b_valid || last==B); otherwise grant B if b_valid.
  - The granted source's ready is high and its key is accepted in the same cycle; `last` is updated.
  - Accepted key `=` or CA: stay IDLE (single-key session).
  - Any other key: go to OWN_A or OWN_B.
- OWN_x: only x's ready may be high (gap_cnt==0). The other source waits with its ready low.
  - Accepted `=` or CA: go to IDLE.
  - Other keys: stay in OWN_x.
- Inactivity counter:
  - Cleared on entry to OWN_x and on every accept.
  - Increments each OWN cycle with no accept; saturates.
  - When it reaches TIMEOUT with no accept in that cycle (timeout fire), neither ready is high. The next cycle: keycode=00100 (CA), newkey=1, timeout_flag=1, state IDLE, `last` = timed-out source.
- An accept in the same cycle the count reaches TIMEOUT takes priority; no timeout fires.
- owner = 01 in OWN_A, 10 in OWN_B, 00 in IDLE (registered with state).
- Reset mid-session: everything returns to its reset values immediately. No CA is injected.

## Timing
- Reset values: keycode=00000, newkey=0, owner=00, timeout_flag=0, gap_cnt=0, inactivity count=0, state IDLE, last=B. a_ready and b_ready are 0 while rst is high.
- Latency: key accepted in cycle n → keycode=key with newkey=1 in cycle n+1.
- Pacing: the next accept is possible no earlier than n+1+GAP_CYCLES, so there are exactly GAP_CYCLES zero cycles between `newkey` pulses at full rate.
- Owner change: IDLE is entered the cycle after the closing accept. The other source can be accepted once gap_cnt==0.
- Timeout: the fire cycle is TIMEOUT cycles after the last owner accept; CA is driven the cycle after the fire cycle.
- Throughput: one key per GAP_CYCLES+1 cycles.

## Test plan
- Reset, then A sends 1_0001, 0_1011, 1_0010, 0_0011 with b_valid held high → four `newkey` pulses carrying exactly those codes, each spaced by GAP_CYCLES zero cycles. B is accepted only after the `=`. owner reads 01 from the first accept until the cycle after `=`.
- Reset, then a_valid and b_valid rise in the same cycle, both with key `=` (00011) → A accepted first, B second, then A again (round robin).
- A sends 1_0101 and stops, TIMEOUT=16 → 16 cycles later the timeout fires. The next cycle shows keycode=00100, newkey=1, timeout_flag=1, owner=00. A pending b_valid is then granted.
- GAP_CYCLES=3, A streams digits back to back → `newkey` pulses are 4 cycles apart. a_ready is low during the gap.
- Assert rst in the middle of an A session while b_valid is high → all outputs return to reset values immediately and no CA is injected. After reset, B is accepted only if a_valid is low.
- A accepts a key in the same cycle the inactivity count reaches TIMEOUT → no timeout fires and the session continues with owner=01.
